fft_seq_ctrl: RTL and testbench

Frame sequencer for the 4-sample/cycle, N=128 parallel FFT pipeline. It tracks input frame position from a valid/start-of-frame stream and drives everything that must stay aligned with it:
- the stage-II delay-line commutator control;
- the address and enable of the stage-0 and stage-1 twiddle ROMs;
- the output framing flags.

It replaces the free-running counter and delayed-reset coefficient enables with one frame-aware controller that also detects framing errors.

---
 rtl/fft_seq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_fft_seq_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fft_seq_ctrl.sv
// Frame sequencer for the parallel FFT pipeline: tracks frame position, drives the commutator
// select, both twiddle ROM ports and the output framing flags, and flags framing errors.
module fft_seq_ctrl #(
   parameter int unsigned N       = 128,
   parameter int unsigned P       = 4,
   parameter int unsigned D       = 16,
   parameter int unsigned OUT_LAT = 2,
   parameter int unsigned AW      = $clog2(N / P)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic          in_sof,
   output logic          bf2_ctrl,
   output logic          coeff_en0,
   output logic [AW-1:0] coeff_addr0,
   output logic          coeff_en1,
   output logic [AW-1:0] coeff_addr1,
   output logic          out_valid,
   output logic          out_sof,
   output logic          out_eof,
   output logic          busy,
   output logic          err_sof,
   output logic          err_gap
);

   localparam int unsigned FC = N / P;
   localparam int unsigned DB = $clog2(D);
   localparam logic [AW-1:0] KLast = AW'(FC - 1);

   typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          en0_q, en0_d;
   logic [AW-1:0] addr0_q, addr0_d;
   logic          bf2_q, bf2_d;
   logic          err_sof_q, err_sof_d;
   logic          err_gap_q, err_gap_d;
   logic [AW:0]   dly_q [D];
   logic [AW:0]   dly_d [D];
   logic [2:0]    ol_q [OUT_LAT];
   logic [2:0]    ol_d [OUT_LAT];
   logic [AW-1:0] k_inc;
   logic          drain_done;
   logic          en1;
   logic [AW-1:0] addr1;

   assign en1   = dly_q[D-1][AW];
   assign addr1 = dly_q[D-1][AW-1:0];

   always_comb begin
      dly_d[0] = {en0_q, addr0_q};
      for (int i = 1; i < int'(D); i++) begin
         dly_d[i] = dly_q[i-1];
      end
      ol_d[0] = {en1, en1 && (addr1 == '0), en1 && (addr1 == KLast)};
      for (int i = 1; i < int'(OUT_LAT); i++) begin
         ol_d[i] = ol_q[i-1];
      end
   end

   // Done once nothing but the final output register still holds a sample.
   always_comb begin
      drain_done = !en0_q;
      for (int i = 0; i < int'(D); i++) begin
         if (dly_q[i][AW]) drain_done = 1'b0;
      end
      for (int i = 0; i < int'(OUT_LAT) - 1; i++) begin
         if (ol_q[i][2]) drain_done = 1'b0;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      en0_d     = 1'b0;
      addr0_d   = addr0_q;
      bf2_d     = 1'b0;
      err_sof_d = 1'b0;
      err_gap_d = 1'b0;
      k_inc     = cnt_q + AW'(1);
      case (state_q)
         StIdle: begin
            if (in_valid && in_sof) begin
               state_d = StRun;
               cnt_d   = '0;
               en0_d   = 1'b1;
               addr0_d = '0;
            end
         end
         StRun: begin
            if (in_valid && in_sof) begin
               err_sof_d = (cnt_q != KLast);
               cnt_d     = '0;
               en0_d     = 1'b1;
               addr0_d   = '0;
            end else if (in_valid && (cnt_q != KLast)) begin
               cnt_d   = k_inc;
               en0_d   = 1'b1;
               addr0_d = k_inc;
               bf2_d   = k_inc[DB];
            end else begin
               // Normal frame end, stray valid after the end, or a gap mid-frame.
               err_gap_d = !in_valid && (cnt_q != KLast);
               state_d   = StFlush;
               cnt_d     = k_inc;
               bf2_d     = k_inc[DB];
            end
         end
         StFlush: begin
            if (in_valid && in_sof) begin
               state_d = StRun;
               cnt_d   = '0;
               en0_d   = 1'b1;
               addr0_d = '0;
            end else if (drain_done) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = k_inc;
               bf2_d = k_inc[DB];
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         en0_q     <= 1'b0;
         addr0_q   <= '0;
         bf2_q     <= 1'b0;
         err_sof_q <= 1'b0;
         err_gap_q <= 1'b0;
         for (int i = 0; i < int'(D); i++) dly_q[i] <= '0;
         for (int i = 0; i < int'(OUT_LAT); i++) ol_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         en0_q     <= en0_d;
         addr0_q   <= addr0_d;
         bf2_q     <= bf2_d;
         err_sof_q <= err_sof_d;
         err_gap_q <= err_gap_d;
         dly_q     <= dly_d;
         ol_q      <= ol_d;
      end
   end

   assign bf2_ctrl    = bf2_q;
   assign coeff_en0   = en0_q;
   assign coeff_addr0 = addr0_q;
   assign coeff_en1   = en1;
   assign coeff_addr1 = addr1;
   assign out_valid   = ol_q[OUT_LAT-1][2];
   assign out_sof     = ol_q[OUT_LAT-1][1];
   assign out_eof     = ol_q[OUT_LAT-1][0];
   assign busy        = (state_q != StIdle);
   assign err_sof     = err_sof_q;
   assign err_gap     = err_gap_q;

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Directed bench for fft_seq_ctrl: cycle-by-cycle checks of the framing scenarios, with
// expected values written out as hand-derived cycle ranges.
module tb_fft_seq_ctrl;

   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_sof;
   logic          bf2_ctrl;
   logic          coeff_en0;
   logic [AW-1:0] coeff_addr0;
   logic          coeff_en1;
   logic [AW-1:0] coeff_addr1;
   logic          out_valid;
   logic          out_sof;
   logic          out_eof;
   logic          busy;
   logic          err_sof;
   logic          err_gap;
   logic [18:0]   all_out;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   fft_seq_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_sof      (in_sof),
      .bf2_ctrl    (bf2_ctrl),
      .coeff_en0   (coeff_en0),
      .coeff_addr0 (coeff_addr0),
      .coeff_en1   (coeff_en1),
      .coeff_addr1 (coeff_addr1),
      .out_valid   (out_valid),
      .out_sof     (out_sof),
      .out_eof     (out_eof),
      .busy        (busy),
      .err_sof     (err_sof),
      .err_gap     (err_gap)
   );

   assign all_out = {bf2_ctrl, coeff_en0, coeff_addr0, coeff_en1, coeff_addr1, out_valid,
                     out_sof, out_eof, busy, err_sof, err_gap};

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
      end
   endtask

   function automatic logic in_rng(input int c, input int lo, input int hi);
      return (c >= lo) && (c <= hi);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst      = 1'b1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      cyc = -1;
      check_eq("reset_state", 32'(all_out), 32'd0);
   endtask

   // One clean frame starting with sof at relative cycle 0.
   task automatic run_single();
      for (int r = 0; r <= 55; r++) begin
         cyc = r;
         check_eq("single_en0", 32'(coeff_en0), 32'(in_rng(r, 1, 32)));
         if (in_rng(r, 1, 32)) begin
            check_eq("single_addr0", 32'(coeff_addr0), 32'(r - 1));
            check_eq("single_bf2", 32'(bf2_ctrl), 32'(r >= 17));
         end
         check_eq("single_en1", 32'(coeff_en1), 32'(in_rng(r, 17, 48)));
         if (in_rng(r, 17, 48)) check_eq("single_addr1", 32'(coeff_addr1), 32'(r - 17));
         check_eq("single_ovalid", 32'(out_valid), 32'(in_rng(r, 19, 50)));
         check_eq("single_osof", 32'(out_sof), 32'(r == 19));
         check_eq("single_oeof", 32'(out_eof), 32'(r == 50));
         check_eq("single_busy", 32'(busy), 32'(in_rng(r, 1, 50)));
         check_eq("single_err", 32'({err_sof, err_gap}), 32'd0);
         in_valid = (r <= 31);
         in_sof   = (r == 0);
         tick();
      end
   endtask

   initial begin
      // Valid without sof while idle: ignored entirely.
      reset_dut();
      for (int c = 0; c <= 12; c++) begin
         cyc = c;
         check_eq("idle_valid_quiet", 32'(all_out), 32'd0);
         in_valid = (c < 10);
         in_sof   = 1'b0;
         tick();
      end

      reset_dut();
      run_single();

      // Three back-to-back frames.
      reset_dut();
      for (int c = 0; c <= 118; c++) begin
         cyc = c;
         check_eq("b2b_en0", 32'(coeff_en0), 32'(in_rng(c, 1, 96)));
         if (in_rng(c, 1, 96)) begin
            check_eq("b2b_addr0", 32'(coeff_addr0), 32'((c - 1) % 32));
            check_eq("b2b_bf2", 32'(bf2_ctrl), 32'(((c - 1) % 32) >= 16));
         end
         check_eq("b2b_ovalid", 32'(out_valid), 32'(in_rng(c, 19, 114)));
         check_eq("b2b_osof", 32'(out_sof), 32'(c == 19 || c == 51 || c == 83));
         check_eq("b2b_oeof", 32'(out_eof), 32'(c == 50 || c == 82 || c == 114));
         check_eq("b2b_busy", 32'(busy), 32'(in_rng(c, 1, 114)));
         check_eq("b2b_err", 32'({err_sof, err_gap}), 32'd0);
         in_valid = (c <= 95);
         in_sof   = (c % 32 == 0) && (c <= 95);
         tick();
      end

      // Second sof mid-frame at cycle 10: resync.
      reset_dut();
      for (int c = 0; c <= 65; c++) begin
         cyc = c;
         check_eq("msof_err_sof", 32'(err_sof), 32'(c == 11));
         check_eq("msof_err_gap", 32'(err_gap), 32'd0);
         check_eq("msof_en0", 32'(coeff_en0), 32'(in_rng(c, 1, 42)));
         if (in_rng(c, 1, 42))
            check_eq("msof_addr0", 32'(coeff_addr0), 32'((c <= 10) ? c - 1 : c - 11));
         check_eq("msof_ovalid", 32'(out_valid), 32'(in_rng(c, 19, 60)));
         check_eq("msof_osof", 32'(out_sof), 32'(c == 19 || c == 29));
         check_eq("msof_oeof", 32'(out_eof), 32'(c == 60));
         check_eq("msof_busy", 32'(busy), 32'(in_rng(c, 1, 60)));
         in_valid = (c <= 41);
         in_sof   = (c == 0 || c == 10);
         tick();
      end

      // Valid drops after cycle 19: truncated frame.
      reset_dut();
      for (int c = 0; c <= 45; c++) begin
         cyc = c;
         check_eq("gap_err_gap", 32'(err_gap), 32'(c == 21));
         check_eq("gap_err_sof", 32'(err_sof), 32'd0);
         check_eq("gap_en0", 32'(coeff_en0), 32'(in_rng(c, 1, 20)));
         if (in_rng(c, 1, 20)) check_eq("gap_addr0", 32'(coeff_addr0), 32'(c - 1));
         check_eq("gap_ovalid", 32'(out_valid), 32'(in_rng(c, 19, 38)));
         check_eq("gap_osof", 32'(out_sof), 32'(c == 19));
         check_eq("gap_oeof", 32'(out_eof), 32'd0);
         check_eq("gap_busy", 32'(busy), 32'(in_rng(c, 1, 38)));
         in_valid = (c <= 19);
         in_sof   = (c == 0);
         tick();
      end

      // Reset at cycle 12 mid-frame, then a fresh frame at cycle 20.
      reset_dut();
      for (int c = 0; c <= 19; c++) begin
         cyc = c;
         if (c >= 13) check_eq("rst_mid_quiet", 32'(all_out), 32'd0);
         in_valid = (c <= 12);
         in_sof   = (c == 0);
         rst      = (c == 12);
         tick();
      end
      rst = 1'b0;
      run_single();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
